arb_requester: RTL and testbench

// - Requester-side agent for one port of the fixed-priority arbiter (req/gnt, combinational grant).
// - Queues burst jobs, raises req_o, holds it while beats are issued on cycles with gnt_i high.
// - Releases the port for one cycle after each burst so lower-priority ports can win.
// - One instance per arbiter port; gnt_i connects to that port's gnt_o bit.

---
 rtl/arb_pkg.sv | 8 +
 rtl/arb_job_fifo.sv | 45 ++++
 rtl/arb_requester.sv | 120 ++++++++++++
 tb/tb_arb_requester.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and defaults for the arbiter requester agent.
package arb_pkg;

  localparam int ARB_LEN_W = 4;

  typedef enum logic [1:0] {ARB_IDLE, ARB_ACTIVE, ARB_GAP} arb_req_state_t;

endpackage

// File: rtl/arb_job_fifo.sv
// Pending-job queue for arb_requester: synchronous FIFO with async active-high reset.
module arb_job_fifo #(
  parameter int W     = 4,
  parameter int DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/arb_requester.sv
// Requester-side agent for one fixed-priority arbiter port: queues burst jobs and issues beats on grant.
// Optional starvation detector enabled by defining ARB_REQ_TIMEOUT_EN.
module arb_requester
  import arb_pkg::*;
#(
  parameter int LEN_W      = ARB_LEN_W,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             job_valid_i,
  input  logic [LEN_W-1:0] job_len_i,
  output logic             job_ready_o,
  output logic             req_o,
  input  logic             gnt_i,
  output logic             beat_valid_o,
  output logic             beat_last_o,
  output logic             busy_o,
  output logic             starve_o
);

  arb_req_state_t   state;
  arb_req_state_t   state_next;
  logic [LEN_W-1:0] rem;
  logic [LEN_W-1:0] fifo_dout;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;

  assign push        = job_valid_i && !fifo_full;
  assign pop         = !fifo_empty && (state == ARB_IDLE || state == ARB_GAP);
  assign job_ready_o = !fifo_full;
  assign busy_o      = (state != ARB_IDLE) || !fifo_empty;

  arb_job_fifo #(
    .W     (LEN_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (push),
    .pop   (pop),
    .din   (job_len_i),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= ARB_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next   = state;
    req_o        = 1'b0;
    beat_valid_o = 1'b0;
    beat_last_o  = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (!fifo_empty) state_next = ARB_ACTIVE;
      end
      ARB_ACTIVE: begin
        req_o        = 1'b1;
        beat_valid_o = gnt_i;
        beat_last_o  = gnt_i && (rem == '0);
        if (gnt_i && (rem == '0)) state_next = ARB_GAP;
      end
      ARB_GAP: begin
        // Port released for this one cycle so lower-priority requesters can win.
        state_next = fifo_empty ? ARB_IDLE : ARB_ACTIVE;
      end
      default: state_next = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rem <= '0;
    end else if (pop) begin
      rem <= fifo_dout;
    end else if (state == ARB_ACTIVE && gnt_i && rem != '0) begin
      rem <= rem - 1'b1;
    end
  end

`ifdef ARB_REQ_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);

  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_inc;
  logic              starve;

  assign wait_inc = (wait_cnt == WAIT_MAX) ? wait_cnt : wait_cnt + 1'b1;

  // Any beat clears both the count and the sticky flag; only stalled ACTIVE cycles advance it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wait_cnt <= '0;
      starve   <= 1'b0;
    end else if (beat_valid_o) begin
      wait_cnt <= '0;
      starve   <= 1'b0;
    end else if (state == ARB_ACTIVE) begin
      wait_cnt <= wait_inc;
      if (wait_inc == WAIT_MAX) starve <= 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end

  assign starve_o = starve;
`else
  assign starve_o = 1'b0;
`endif

endmodule

// File: tb/tb_arb_requester.sv
// Directed self-checking bench for arb_requester; gnt_i is driven directly.
module tb_arb_requester;

   logic       clk_i = 1'b0;
   logic       rst_i;
   logic       job_valid_i;
   logic [3:0] job_len_i;
   logic       job_ready_o;
   logic       req_o;
   logic       gnt_i;
   logic       beat_valid_o;
   logic       beat_last_o;
   logic       busy_o;
   logic       starve_o;

   int total = 0;
   int bad   = 0;

   always #5 clk_i = ~clk_i;

   arb_requester #(
      .LEN_W      (4),
      .FIFO_DEPTH (4),
      .TIMEOUT    (16)
   ) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .job_valid_i  (job_valid_i),
      .job_len_i    (job_len_i),
      .job_ready_o  (job_ready_o),
      .req_o        (req_o),
      .gnt_i        (gnt_i),
      .beat_valid_o (beat_valid_o),
      .beat_last_o  (beat_last_o),
      .busy_o       (busy_o),
      .starve_o     (starve_o)
   );

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic test_reset();
      logic [5:0] cur;
      rst_i = 1'b1; job_valid_i = 1'b0; job_len_i = '0; gnt_i = 1'b0;
      repeat (2) @(posedge clk_i);
      #2;
      cur = {req_o, beat_valid_o, beat_last_o, job_ready_o, busy_o, starve_o};
      total++;
      if (cur !== 6'b000100) begin
         bad++;
         $display("FAIL reset_outputs got=%b exp=%b", cur, 6'b000100);
      end
      rst_i = 1'b0;
      tick();
   endtask

   // {req, beat_valid, beat_last, busy} per cycle after the accept edge
   task automatic test_single();
      logic [3:0] e [6] = '{4'b0001, 4'b1101, 4'b1101, 4'b1111, 4'b0001, 4'b0000};
      logic [3:0] cur;
      gnt_i = 1'b1; job_len_i = 4'd2; job_valid_i = 1'b1;
      #1;
      total++;
      if (job_ready_o !== 1'b1) begin
         bad++;
         $display("FAIL single_ready got=%b exp=1", job_ready_o);
      end
      tick();
      job_valid_i = 1'b0;
      for (int i = 0; i < 6; i++) begin
         #1;
         cur = {req_o, beat_valid_o, beat_last_o, busy_o};
         total++;
         if (cur !== e[i]) begin
            bad++;
            $display("FAIL single_cyc%0d got=%b exp=%b", i, cur, e[i]);
         end
         tick();
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0] e [9] = '{4'b0001, 4'b1101, 4'b1101, 4'b1101, 4'b1111,
                            4'b0001, 4'b1111, 4'b0001, 4'b0000};
      logic [3:0] cur;
      gnt_i = 1'b1; job_valid_i = 1'b1; job_len_i = 4'd3;
      tick();
      job_len_i = 4'd0;
      #1;
      cur = {req_o, beat_valid_o, beat_last_o, busy_o};
      total++;
      if (cur !== e[0]) begin
         bad++;
         $display("FAIL b2b_cyc0 got=%b exp=%b", cur, e[0]);
      end
      tick();
      job_valid_i = 1'b0;
      for (int i = 1; i < 9; i++) begin
         #1;
         cur = {req_o, beat_valid_o, beat_last_o, busy_o};
         total++;
         if (cur !== e[i]) begin
            bad++;
            $display("FAIL b2b_cyc%0d got=%b exp=%b", i, cur, e[i]);
         end
         tick();
      end
   endtask

   task automatic test_preempt();
      logic       g [11] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      logic [3:0] e [11] = '{4'b0001, 4'b1101, 4'b1001, 4'b1001, 4'b1101, 4'b1101,
                             4'b1101, 4'b1101, 4'b1111, 4'b0001, 4'b0000};
      logic [3:0] cur;
      int beats = 0;
      gnt_i = 1'b1; job_valid_i = 1'b1; job_len_i = 4'd5;
      tick();
      job_valid_i = 1'b0;
      for (int i = 0; i < 11; i++) begin
         gnt_i = g[i];
         #1;
         cur = {req_o, beat_valid_o, beat_last_o, busy_o};
         if (beat_valid_o === 1'b1) beats++;
         total++;
         if (cur !== e[i]) begin
            bad++;
            $display("FAIL preempt_cyc%0d got=%b exp=%b", i, cur, e[i]);
         end
         tick();
      end
      total++;
      if (beats != 6) begin
         bad++;
         $display("FAIL preempt_beats got=%0d exp=6", beats);
      end
   endtask

   // One job moves into ACTIVE on the second edge, so five are taken before the queue fills.
   task automatic test_fill();
      int acc = 0;
      int ready_cyc = -1;
      int beats = 0;
      int cyc = 0;
      gnt_i = 1'b0; job_valid_i = 1'b1; job_len_i = 4'd0;
      for (int i = 0; i < 8; i++) begin
         #1;
         if (job_ready_o === 1'b1) acc++;
         tick();
      end
      total++;
      if (acc != 5) begin
         bad++;
         $display("FAIL fill_accepts got=%0d exp=5", acc);
      end
      #1;
      total++;
      if (job_ready_o !== 1'b0) begin
         bad++;
         $display("FAIL fill_ready_low got=%b exp=0", job_ready_o);
      end
      job_valid_i = 1'b0; gnt_i = 1'b1;
      while (cyc < 40) begin
         #1;
         if (ready_cyc < 0 && job_ready_o === 1'b1) ready_cyc = cyc;
         if (beat_valid_o === 1'b1) beats++;
         if (busy_o === 1'b0) break;
         tick();
         cyc++;
      end
      total++;
      if (ready_cyc != 2) begin
         bad++;
         $display("FAIL fill_ready_rise got=%0d exp=2", ready_cyc);
      end
      total++;
      if (beats != 5) begin
         bad++;
         $display("FAIL fill_beats got=%0d exp=5", beats);
      end
      total++;
      if (cyc >= 40) begin
         bad++;
         $display("FAIL fill_drain_timeout got=%0d exp=<40", cyc);
      end
      tick();
   endtask

   task automatic test_reset_mid_burst();
      logic [3:0] cur;
      int stray = 0;
      gnt_i = 1'b1; job_valid_i = 1'b1; job_len_i = 4'd4;
      tick();
      job_len_i = 4'd1;
      tick();
      job_valid_i = 1'b0;
      tick();
      tick();
      #1;
      total++;
      if ({req_o, beat_valid_o} !== 2'b11) begin
         bad++;
         $display("FAIL rst_pre_active got=%b exp=11", {req_o, beat_valid_o});
      end
      rst_i = 1'b1;
      #1;
      cur = {req_o, beat_valid_o, job_ready_o, busy_o};
      total++;
      if (cur !== 4'b0010) begin
         bad++;
         $display("FAIL rst_mid got=%b exp=0010", cur);
      end
      tick();
      rst_i = 1'b0;
      for (int i = 0; i < 8; i++) begin
         #1;
         if (beat_valid_o !== 1'b0 || busy_o !== 1'b0) stray++;
         tick();
      end
      total++;
      if (stray != 0) begin
         bad++;
         $display("FAIL rst_no_resume got=%0d exp=0", stray);
      end
      job_valid_i = 1'b1; job_len_i = 4'd0;
      tick();
      job_valid_i = 1'b0;
      tick();
      #1;
      total++;
      if ({beat_valid_o, beat_last_o} !== 2'b11) begin
         bad++;
         $display("FAIL rst_new_job got=%b exp=11", {beat_valid_o, beat_last_o});
      end
      tick();
      tick();
   endtask

   task automatic test_starve();
      logic exp_s;
      int errs = 0;
      gnt_i = 1'b0; job_valid_i = 1'b1; job_len_i = 4'd0;
      tick();
      job_valid_i = 1'b0;
      tick();
      for (int j = 0; j < 20; j++) begin
`ifdef ARB_REQ_TIMEOUT_EN
         exp_s = (j >= 16);
`else
         exp_s = 1'b0;
`endif
         #1;
         if (starve_o !== exp_s || req_o !== 1'b1) begin
            errs++;
            $display("FAIL starve_cyc%0d got=%b exp=%b", j, starve_o, exp_s);
         end
         tick();
      end
      total++;
      if (errs != 0) begin
         bad++;
         $display("FAIL starve_window got=%0d exp=0", errs);
      end
`ifdef ARB_REQ_TIMEOUT_EN
      exp_s = 1'b1;
`else
      exp_s = 1'b0;
`endif
      gnt_i = 1'b1;
      #1;
      total++;
      if ({beat_valid_o, starve_o} !== {1'b1, exp_s}) begin
         bad++;
         $display("FAIL starve_at_beat got=%b exp=%b", {beat_valid_o, starve_o}, {1'b1, exp_s});
      end
      tick();
      #1;
      total++;
      if (starve_o !== 1'b0) begin
         bad++;
         $display("FAIL starve_clear got=%b exp=0", starve_o);
      end
      tick();
      tick();
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_preempt();
      test_fill();
      test_reset_mid_burst();
      test_starve();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
